btn_event_ctrl: RTL and testbench
=================================

// Module: btn_event_ctrl
// PURPOSE
//  Turns NBTN debounced button levels (DeBounce DB_out outputs) into discrete press events.
//  - Short press: reported on release.
//  - Long press: reported once, when the hold time reaches LONG_CNT cycles.
//  Pending events are buffered per button and granted round-robin onto one valid/ready
//  event port, which feeds the UART TX command path.
// PARAMETERS
//  NBTN     4         number of button inputs (2..16)
//  IDW      2         evt_id width, = ceil(log2(NBTN))
//  CW       26        hold-counter width; must satisfy 2^CW > LONG_CNT
//  LONG_CNT 38000000  hold cycles that qualify as a long press (1 s at 38 MHz)
// PORTS
//  clk        in   1     system clock, all logic on posedge
//  n_reset    in   1     synchronous reset, active low
//  db_in      in   NBTN  debounced button levels, 1 = pressed, already synchronous to clk
//  evt_valid  out  1     event presented on evt_id/evt_long
//  evt_ready  in   1     consumer accepts the event when evt_valid & evt_ready
//  evt_id     out  IDW   index of the button that produced the event
//  evt_long   out  1     1 = long press, 0 = short press
//  pending    out  NBTN  per-button OR of short/long pending flags
//  ovf_clr    in   1     clears overflow (single-cycle pulse)
//  overflow   out  1     sticky: an event was dropped because its pending slot was full
// BEHAVIOUR
//  Reset (n_reset=0 at posedge):
//  - All of the following clear to 0: evt_valid, evt_id, evt_long, pending, overflow,
//    db_prev, hold counters, rr_ptr.
//  - The FSM returns to IDLE, including mid-handshake; an in-flight event is discarded.
//  - A button held across reset release is seen as a new press (db_prev=0).
//  Per button i, with db_prev[i] = registered db_in[i]:
//  - While db_in[i]=1: cnt[i] increments each cycle and saturates at LONG_CNT.
//    The cycle cnt[i] steps LONG_CNT-1 -> LONG_CNT raises a long event (once per hold).
//  - Falling edge (db_prev=1, db_in=0): if cnt[i] < LONG_CNT, raise a short event.
//    cnt[i] <= 0 in all cases, so no short event follows a long one.
//  - A press lasting k cycles at db_in gives cnt = k at release.
//  Pending:
//  - Each raised event sets spend[i] or lpend[i] at the next posedge.
//  - If the slot is already set and not being granted that cycle, the event is dropped
//    and overflow <= 1.
//  - Set beats grant-clear on the same bit in the same cycle: the new event is kept and
//    overflow does not set.
//  - Overflow stays set until ovf_clr or reset. If ovf_clr and a drop occur in the same
//    cycle, set wins.
//  Arbiter FSM:
//  - IDLE: if any pending, pick the first button j with spend|lpend, scanning from rr_ptr
//    upward and wrapping.
//    - Load evt_id=j, evt_long=lpend[j] (long before short for the same button).
//    - Clear that one flag, evt_valid <= 1, go to PRESENT.
//  - PRESENT: evt_valid, evt_id and evt_long are held stable.
//    - On evt_valid & evt_ready: evt_valid <= 0, rr_ptr <= (evt_id+1) mod NBTN, go to IDLE.
//    - evt_ready with evt_valid=0 is ignored.
//  Latency:
//  - Event raised in cycle t -> pending visible at t+1 -> evt_valid at t+2, if in IDLE.
//  - After a handshake there is at least 1 idle cycle before the next evt_valid.
//  - Peak throughput: 1 event per 2 cycles.
//  - A button with both flags set yields long then short on consecutive grants only if
//    no other button is pending (round-robin moves past it).
// TESTING (LONG_CNT=8, NBTN=4)
//  - db_in[2] high 3 cycles then low, evt_ready=1
//    -> one event id=2 long=0; evt_valid 2 cycles after the falling edge, up 1 cycle.
//  - db_in[1] high 20 cycles -> one id=1 long=1 after 8 high cycles; no event on release.
//  - db_in[0] and db_in[3] short presses released the same cycle, rr_ptr=0, evt_ready=1
//    -> id=0 then id=3; a later repeat with rr_ptr=1 -> id=3 first.
//  - evt_ready=0 for 50 cycles, two short presses on button 2
//    -> evt_id/evt_long stable while stalled; second press held pending; a third press
//       sets overflow=1; ovf_clr -> overflow=0.
//  - n_reset pulsed low while evt_valid=1
//    -> next cycle all outputs 0, pending=0; no event is replayed after reset.
//  - Grant of button 1 and a new short event on button 1 in the same cycle
//    -> spend[1] stays 1, overflow stays 0, second event delivered later.

Source files
------------

// File: rtl/btn_event_ctrl.sv
// Debounced button levels -> short/long press events, one pending slot per kind per button,
// granted round-robin onto a valid/ready port; event raised at t shows as evt_valid at t+2.
module btn_event_ctrl #(
    parameter int NBTN     = 4,
    parameter int IDW      = 2,
    parameter int CW       = 26,
    parameter int LONG_CNT = 38000000
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [NBTN-1:0] db_in,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_id,
    output logic            evt_long,
    output logic [NBTN-1:0] pending,
    input  logic            ovf_clr,
    output logic            overflow
);

    localparam logic [CW-1:0]  LONG_V  = CW'(LONG_CNT);
    localparam logic [CW-1:0]  LONG_M1 = CW'(LONG_CNT - 1);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NBTN - 1);

    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_nxt;

    logic [NBTN-1:0] db_prev, spend, lpend;
    logic [NBTN-1:0] short_evt, long_evt, pend_any, clr_s, clr_l;
    logic [CW-1:0]   cnt [NBTN];
    logic [IDW-1:0]  rr_ptr, pick;
    logic            found, load, done, drop;
    int              idx;

    always_comb begin
        short_evt = '0;
        long_evt  = '0;
        for (int i = 0; i < NBTN; i++) begin
            long_evt[i]  = db_in[i] && (cnt[i] == LONG_M1);
            short_evt[i] = db_prev[i] && !db_in[i] && (cnt[i] < LONG_V);
        end
    end

    assign pend_any = spend | lpend;
    assign pending  = pend_any;

    // First pending button at or above rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NBTN; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NBTN)
                idx = idx - NBTN;
            if (!found && pend_any[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        done      = 1'b0;
        clr_s     = '0;
        clr_l     = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = PRESENT;
                    if (lpend[pick])
                        clr_l[pick] = 1'b1;
                    else
                        clr_s[pick] = 1'b1;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new event into a slot that is being granted this cycle is kept, not dropped
    assign drop = |((short_evt & spend & ~clr_s) | (long_evt & lpend & ~clr_l));

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state     <= IDLE;
            db_prev   <= '0;
            spend     <= '0;
            lpend     <= '0;
            overflow  <= 1'b0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
            rr_ptr    <= '0;
            for (int i = 0; i < NBTN; i++)
                cnt[i] <= '0;
        end else begin
            state   <= state_nxt;
            db_prev <= db_in;
            for (int i = 0; i < NBTN; i++) begin
                if (db_in[i]) begin
                    if (cnt[i] != LONG_V)
                        cnt[i] <= cnt[i] + CW'(1);
                end else begin
                    cnt[i] <= '0;
                end
            end
            spend <= (spend & ~clr_s) | short_evt;
            lpend <= (lpend & ~clr_l) | long_evt;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (load) begin
                evt_valid <= 1'b1;
                evt_id    <= pick;
                evt_long  <= lpend[pick];
            end else if (done) begin
                evt_valid <= 1'b0;
                rr_ptr    <= (evt_id == LAST_ID) ? '0 : evt_id + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with NBTN=4, LONG_CNT=8.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [3:0] db_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_long;
    logic [3:0] pending;
    logic       ovf_clr;
    logic       overflow;

    int nvec = 0;
    int nerr = 0;

    logic [1:0] got_id[$];
    logic       got_long[$];

    btn_event_ctrl #(.NBTN(4), .IDW(2), .CW(4), .LONG_CNT(8)) dut (
        .clk(clk), .n_reset(n_reset), .db_in(db_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_long(evt_long), .pending(pending), .ovf_clr(ovf_clr),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records every handshake seen at the current step, then advances one cycle
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            if (evt_valid && evt_ready) begin
                got_id.push_back(evt_id);
                got_long.push_back(evt_long);
            end
            tick();
        end
    endtask

    task automatic press(input int btn, input int len);
        db_in[btn] = 1'b1;
        for (int c = 0; c < len; c++) tick();
        db_in[btn] = 1'b0;
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        db_in = '0; evt_ready = 1'b0; ovf_clr = 1'b0; n_reset = 1'b0;
        tick(); tick();
        nvec++; if (evt_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        nvec++; if (evt_id !== 2'd0) begin nerr++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        nvec++; if (evt_long !== 1'b0) begin nerr++; $display("FAIL reset_long: got %b want 0", evt_long); end
        nvec++; if (pending !== 4'b0000) begin nerr++; $display("FAIL reset_pending: got %b want 0000", pending); end
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_short();
        int extra;
        evt_ready = 1'b1;
        db_in = 4'b0100;
        tick(); tick(); tick();
        db_in = 4'b0000;
        nvec++; if (pending !== 4'b0000) begin nerr++; $display("FAIL short_pend_early: got %b want 0000", pending); end
        tick();
        nvec++; if (pending !== 4'b0100) begin nerr++; $display("FAIL short_pend: got %b want 0100", pending); end
        nvec++; if (evt_valid !== 1'b0) begin nerr++; $display("FAIL short_valid_early: got %b want 0", evt_valid); end
        tick();
        nvec++; if ({evt_valid, evt_id, evt_long} !== {1'b1, 2'd2, 1'b0}) begin
            nerr++; $display("FAIL short_event: got v=%b id=%0d long=%b want v=1 id=2 long=0", evt_valid, evt_id, evt_long); end
        tick();
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (evt_valid) extra++;
            tick();
        end
        nvec++; if (extra !== 0) begin nerr++; $display("FAIL short_one_cycle: got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_long();
        int nv, vstep;
        logic [1:0] id;
        logic lg;
        nv = 0; vstep = -1; id = '0; lg = 1'b0;
        evt_ready = 1'b1;
        db_in = 4'b0010;
        for (int s = 1; s <= 30; s++) begin
            tick();
            if (s == 20) db_in = 4'b0000;
            if (evt_valid) begin nv++; vstep = s; id = evt_id; lg = evt_long; end
        end
        nvec++; if (nv !== 1) begin nerr++; $display("FAIL long_count: got %0d events want 1", nv); end
        nvec++; if (vstep !== 9) begin nerr++; $display("FAIL long_latency: got step %0d want 9", vstep); end
        nvec++; if ({id, lg} !== {2'd1, 1'b1}) begin nerr++; $display("FAIL long_event: got id=%0d long=%b want id=1 long=1", id, lg); end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        db_in = 4'b1001;
        tick(); tick();
        db_in = 4'b0000;
        got_id.delete(); got_long.delete();
        run_cycles(10);
        nvec++; if (got_id.size() !== 2) begin nerr++; $display("FAIL rr0_count: got %0d want 2", got_id.size()); end
        else begin
            nvec++; if ({got_id[0], got_id[1]} !== {2'd0, 2'd3}) begin
                nerr++; $display("FAIL rr0_order: got %0d,%0d want 0,3", got_id[0], got_id[1]); end
        end
        press(0, 2);
        run_cycles(6);
        db_in = 4'b1001;
        tick(); tick();
        db_in = 4'b0000;
        got_id.delete(); got_long.delete();
        run_cycles(10);
        nvec++; if (got_id.size() !== 2) begin nerr++; $display("FAIL rr1_count: got %0d want 2", got_id.size()); end
        else begin
            nvec++; if ({got_id[0], got_id[1]} !== {2'd3, 2'd0}) begin
                nerr++; $display("FAIL rr1_order: got %0d,%0d want 3,0", got_id[0], got_id[1]); end
        end
    endtask

    task automatic test_stall();
        int bad;
        evt_ready = 1'b0;
        press(2, 2);
        nvec++; if ({evt_valid, evt_id, evt_long} !== {1'b1, 2'd2, 1'b0}) begin
            nerr++; $display("FAIL stall_first: got v=%b id=%0d long=%b want v=1 id=2 long=0", evt_valid, evt_id, evt_long); end
        press(2, 2);
        nvec++; if ({pending, overflow} !== {4'b0100, 1'b0}) begin
            nerr++; $display("FAIL stall_second: got pend=%b ovf=%b want pend=0100 ovf=0", pending, overflow); end
        press(2, 2);
        nvec++; if ({pending, overflow} !== {4'b0100, 1'b1}) begin
            nerr++; $display("FAIL stall_overflow: got pend=%b ovf=%b want pend=0100 ovf=1", pending, overflow); end
        bad = 0;
        for (int c = 0; c < 32; c++) begin
            if ({evt_valid, evt_id, evt_long} !== {1'b1, 2'd2, 1'b0}) bad++;
            tick();
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL stall_stable: got %0d unstable cycles want 0", bad); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        evt_ready = 1'b1;
        got_id.delete(); got_long.delete();
        run_cycles(8);
        nvec++; if (got_id.size() !== 2) begin nerr++; $display("FAIL stall_drain: got %0d events want 2", got_id.size()); end
        else begin
            nvec++; if ({got_id[0], got_id[1]} !== {2'd2, 2'd2}) begin
                nerr++; $display("FAIL stall_drain_id: got %0d,%0d want 2,2", got_id[0], got_id[1]); end
        end
    endtask

    task automatic test_reset_midflight();
        evt_ready = 1'b0;
        press(3, 2);
        press(3, 2);
        press(3, 2);
        nvec++; if ({evt_valid, evt_id, pending, overflow} !== {1'b1, 2'd3, 4'b1000, 1'b1}) begin
            nerr++; $display("FAIL pre_reset: got v=%b id=%0d pend=%b ovf=%b want v=1 id=3 pend=1000 ovf=1",
                             evt_valid, evt_id, pending, overflow); end
        n_reset = 1'b0;
        tick();
        nvec++; if ({evt_valid, evt_id, evt_long, pending, overflow} !== 9'd0) begin
            nerr++; $display("FAIL midflight_reset: got v=%b id=%0d long=%b pend=%b ovf=%b want all 0",
                             evt_valid, evt_id, evt_long, pending, overflow); end
        n_reset = 1'b1;
        evt_ready = 1'b1;
        got_id.delete(); got_long.delete();
        run_cycles(20);
        nvec++; if (got_id.size() !== 0) begin nerr++; $display("FAIL no_replay: got %0d events want 0", got_id.size()); end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        press(0, 2);
        press(1, 2);
        db_in[1] = 1'b1;
        tick(); tick();
        evt_ready = 1'b1;
        tick();
        nvec++; if (evt_valid !== 1'b0) begin nerr++; $display("FAIL b2b_idle: got %b want 0", evt_valid); end
        db_in[1] = 1'b0;
        evt_ready = 1'b0;
        tick();
        nvec++; if ({evt_valid, evt_id, evt_long, pending, overflow} !== {1'b1, 2'd1, 1'b0, 4'b0010, 1'b0}) begin
            nerr++; $display("FAIL b2b_collide: got v=%b id=%0d long=%b pend=%b ovf=%b want v=1 id=1 long=0 pend=0010 ovf=0",
                             evt_valid, evt_id, evt_long, pending, overflow); end
        evt_ready = 1'b1;
        got_id.delete(); got_long.delete();
        run_cycles(8);
        nvec++; if (got_id.size() !== 2) begin nerr++; $display("FAIL b2b_count: got %0d events want 2", got_id.size()); end
        else begin
            nvec++; if ({got_id[0], got_id[1]} !== {2'd1, 2'd1}) begin
                nerr++; $display("FAIL b2b_id: got %0d,%0d want 1,1", got_id[0], got_id[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_round_robin();
        test_stall();
        test_reset_midflight();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
